// File: rtl/reg_scoreboard.sv
// Issue-side hazard scoreboard for an 8-entry register file with two retire ports (E and M).
// Tracks in-flight writes per register and stalls issue on RAW hazards or counter saturation.
module reg_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [2:0] issue_srcA,
    input  logic [2:0] issue_srcB,
    input  logic [2:0] issue_dst,
    input  logic       issue_wr,
    input  logic       retE_valid,
    input  logic [2:0] retE_dst,
    input  logic       retM_valid,
    input  logic [2:0] retM_dst,
    input  logic       flush,
    output logic       stall,
    output logic [6:0] busy_mask,
    output logic       err
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [CNT_W-1:0] pending_q [1:7];
    logic [CNT_W-1:0] pending_d [1:7];
    logic             err_q;
    logic             err_d;

    // R0 entry is a constant zero so source/destination indexing needs no special case.
    logic [CNT_W-1:0] cnt [8];
    logic [CNT_W:0]   sum [1:7];
    logic [CNT_W:0]   dec [1:7];

    logic raw_a;
    logic raw_b;
    logic sat;
    logic accept;
    logic inc;
    logic underflow;

    always_comb begin
        cnt[0] = '0;
        for (int r = 1; r < 8; r++) begin
            cnt[r] = pending_q[r];
        end
    end

    always_comb begin
        for (int r = 1; r < 8; r++) begin
            busy_mask[r-1] = (pending_q[r] != '0);
        end
    end

    // Hazards look only at registered counts; retirements this cycle do not bypass.
    always_comb begin
        raw_a       = (issue_srcA != 3'd0) && (cnt[issue_srcA] != '0);
        raw_b       = (issue_srcB != 3'd0) && (cnt[issue_srcB] != '0);
        sat         = issue_wr && (issue_dst != 3'd0) && (cnt[issue_dst] == CntMax);
        issue_ready = reset_ && !flush && !raw_a && !raw_b && !sat;
        stall       = reset_ && issue_valid && !issue_ready;
        accept      = issue_valid && issue_ready;
    end

    always_comb begin
        underflow = 1'b0;
        inc       = 1'b0;
        for (int r = 1; r < 8; r++) begin
            inc    = accept && issue_wr && (issue_dst == 3'(r));
            sum[r] = {1'b0, pending_q[r]} + (CNT_W+1)'(inc);
            dec[r] = (CNT_W+1)'(retE_valid && (retE_dst == 3'(r)))
                   + (CNT_W+1)'(retM_valid && (retM_dst == 3'(r)));
            if (dec[r] > sum[r]) begin
                pending_d[r] = '0;
                underflow    = 1'b1;
            end else begin
                pending_d[r] = CNT_W'(sum[r] - dec[r]);
            end
        end
        err_d = err_q | underflow;
        if (flush) begin
            for (int r = 1; r < 8; r++) begin
                pending_d[r] = '0;
            end
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int r = 1; r < 8; r++) begin
                pending_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 1; r < 8; r++) begin
                pending_q[r] <= pending_d[r];
            end
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one task per scenario, inline comparisons.
// Inputs change 1 time unit after posedge; outputs are sampled 1 unit later.
module tb_reg_scoreboard;

    logic       clk;
    logic       reset_;
    logic       issue_valid;
    logic       issue_ready;
    logic [2:0] issue_srcA;
    logic [2:0] issue_srcB;
    logic [2:0] issue_dst;
    logic       issue_wr;
    logic       retE_valid;
    logic [2:0] retE_dst;
    logic       retM_valid;
    logic [2:0] retM_dst;
    logic       flush;
    logic       stall;
    logic [6:0] busy_mask;
    logic       err;

    int checks   = 0;
    int failures = 0;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk         (clk),
        .reset_      (reset_),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_srcA  (issue_srcA),
        .issue_srcB  (issue_srcB),
        .issue_dst   (issue_dst),
        .issue_wr    (issue_wr),
        .retE_valid  (retE_valid),
        .retE_dst    (retE_dst),
        .retM_valid  (retM_valid),
        .retM_dst    (retM_dst),
        .flush       (flush),
        .stall       (stall),
        .busy_mask   (busy_mask),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        issue_valid = 1'b0;
        issue_srcA  = 3'd0;
        issue_srcB  = 3'd0;
        issue_dst   = 3'd0;
        issue_wr    = 1'b0;
        retE_valid  = 1'b0;
        retE_dst    = 3'd0;
        retM_valid  = 1'b0;
        retM_dst    = 3'd0;
        flush       = 1'b0;
    endtask

    task automatic issue_write(input logic [2:0] dst);
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_dst   = dst;
    endtask

    task automatic test_reset;
        idle();
        reset_      = 1'b0;
        issue_valid = 1'b1;
        #12;
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready: got %b want 0", issue_ready);
        end
        checks++;
        if (busy_mask !== 7'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b want 0000000", busy_mask);
        end
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err: got %b want 0", err);
        end
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b want 0", stall);
        end
        tick();
        reset_ = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL release_ready: got ready=%b stall=%b want ready=1 stall=0",
                     issue_ready, stall);
        end
        idle();
        tick();
    endtask

    task automatic test_r0;
        issue_write(3'd0);
        retE_valid = 1'b1;
        retE_dst   = 3'd0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (issue_ready !== 1'b1 || stall !== 1'b0) begin
                failures++;
                $display("FAIL r0_ready[%0d]: got ready=%b stall=%b want 1/0",
                         i, issue_ready, stall);
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (busy_mask !== 7'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL r0_state: got busy=%b err=%b want 0000000/0", busy_mask, err);
        end
    endtask

    task automatic test_raw;
        tick();
        issue_write(3'd3);
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL raw_issue_ready: got %b want 1", issue_ready);
        end
        tick();
        idle();
        issue_valid = 1'b1;
        issue_srcA  = 3'd3;
        #1;
        checks++;
        if (stall !== 1'b1 || busy_mask !== 7'b0000100) begin
            failures++;
            $display("FAIL raw_stall: got stall=%b busy=%b want 1/0000100", stall, busy_mask);
        end
        tick();
        retE_valid = 1'b1;
        retE_dst   = 3'd3;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL raw_retire_cycle: got stall=%b want 1", stall);
        end
        tick();
        retE_valid = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || busy_mask !== 7'b0) begin
            failures++;
            $display("FAIL raw_unstall: got stall=%b busy=%b want 0/0000000", stall, busy_mask);
        end
        // srcB path on its own
        tick();
        idle();
        issue_write(3'd6);
        tick();
        idle();
        issue_valid = 1'b1;
        issue_srcB  = 3'd6;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL raw_srcB: got stall=%b want 1", stall);
        end
        retE_valid = 1'b1;
        retE_dst   = 3'd6;
        tick();
        idle();
    endtask

    task automatic test_sat;
        tick();
        issue_write(3'd5);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (issue_ready !== 1'b1) begin
                failures++;
                $display("FAIL sat_fill[%0d]: got ready=%b want 1", i, issue_ready);
            end
            tick();
        end
        #1;
        checks++;
        if (issue_ready !== 1'b0 || stall !== 1'b1 || busy_mask !== 7'b0010000) begin
            failures++;
            $display("FAIL sat_block: got ready=%b stall=%b busy=%b want 0/1/0010000",
                     issue_ready, stall, busy_mask);
        end
        retM_valid = 1'b1;
        retM_dst   = 3'd5;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL sat_retire_cycle: got ready=%b want 0", issue_ready);
        end
        tick();
        retM_valid = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL sat_unblock: got ready=%b want 1", issue_ready);
        end
        tick();
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL sat_refull: got ready=%b want 0", issue_ready);
        end
        idle();
        retE_valid = 1'b1;
        retE_dst   = 3'd5;
        retM_valid = 1'b1;
        retM_dst   = 3'd5;
        tick();
        retM_valid = 1'b0;
        tick();
        idle();
        #1;
        checks++;
        if (busy_mask !== 7'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL sat_drain: got busy=%b err=%b want 0000000/0", busy_mask, err);
        end
    endtask

    task automatic test_same_cycle;
        tick();
        issue_write(3'd4);
        tick();
        retE_valid = 1'b1;
        retE_dst   = 3'd4;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            failures++;
            $display("FAIL same_ready: got %b want 1", issue_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_mask !== 7'b0001000) begin
            failures++;
            $display("FAIL same_net: got busy=%b want 0001000", busy_mask);
        end
        retE_valid = 1'b1;
        retE_dst   = 3'd4;
        tick();
        idle();
        #1;
        checks++;
        if (busy_mask !== 7'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL same_drain: got busy=%b err=%b want 0000000/0", busy_mask, err);
        end
    endtask

    task automatic test_flush;
        tick();
        issue_write(3'd1);
        tick();
        issue_write(3'd4);
        tick();
        tick();
        idle();
        #1;
        checks++;
        if (busy_mask !== 7'b0001001) begin
            failures++;
            $display("FAIL flush_setup: got busy=%b want 0001001", busy_mask);
        end
        // R6 is idle, so this M retire would underflow if the flush did not mask it
        issue_write(3'd2);
        flush      = 1'b1;
        retE_valid = 1'b1;
        retE_dst   = 3'd1;
        retM_valid = 1'b1;
        retM_dst   = 3'd6;
        #1;
        checks++;
        if (issue_ready !== 1'b0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready: got ready=%b stall=%b want 0/1", issue_ready, stall);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_mask !== 7'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear: got busy=%b err=%b want 0000000/0", busy_mask, err);
        end
    endtask

    task automatic test_dual;
        tick();
        issue_write(3'd2);
        tick();
        tick();
        idle();
        retE_valid = 1'b1;
        retE_dst   = 3'd2;
        retM_valid = 1'b1;
        retM_dst   = 3'd2;
        #1;
        checks++;
        if (busy_mask !== 7'b0000010) begin
            failures++;
            $display("FAIL dual_setup: got busy=%b want 0000010", busy_mask);
        end
        tick();
        #1;
        checks++;
        if (busy_mask !== 7'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL dual_retire: got busy=%b err=%b want 0000000/0", busy_mask, err);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy_mask !== 7'b0 || err !== 1'b1) begin
            failures++;
            $display("FAIL dual_underflow: got busy=%b err=%b want 0000000/1", busy_mask, err);
        end
        tick();
        tick();
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
    endtask

    task automatic test_reset_midop;
        issue_write(3'd7);
        tick();
        idle();
        #1;
        checks++;
        if (busy_mask !== 7'b1000000) begin
            failures++;
            $display("FAIL midreset_setup: got busy=%b want 1000000", busy_mask);
        end
        issue_valid = 1'b1;
        reset_      = 1'b0;
        #1;
        checks++;
        if (busy_mask !== 7'b0 || err !== 1'b0 || issue_ready !== 1'b0) begin
            failures++;
            $display("FAIL midreset_clear: got busy=%b err=%b ready=%b want 0000000/0/0",
                     busy_mask, err, issue_ready);
        end
        tick();
        tick();
        reset_ = 1'b1;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || busy_mask !== 7'b0) begin
            failures++;
            $display("FAIL midreset_release: got ready=%b busy=%b want 1/0000000",
                     issue_ready, busy_mask);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_r0();
        test_raw();
        test_sat();
        test_same_cycle();
        test_flush();
        test_dual();
        test_reset_midop();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
